uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares the single UART_wrapper transmit path (trmt/resp/tx_done) among NUM_REQ
//  response sources, e.g. the command processor, the tour-solution player and
//  the fault reporter. Grants round-robin and latches the winner's byte. Fires a
//  1-clk trmt, tracks tx_done through a full byte, then pulses done to the owner.
//  Sits between the requesting blocks and UART_wrapper; RX/cmd path untouched.
// PARAMETERS
//  NUM_REQ    3      number of requesters (2..8)
//  TO_CYCLES  65536  timeout bound in clks per byte (only with UART_ARB_TIMEOUT_EN)
// PORTS
//  clk        in   1          50MHz system clock
//  rst_n      in   1          reset, synchronous, active low
//  req        in   NUM_REQ    req[i] held high with req_data stable until ack[i]
//  req_data   in   8*NUM_REQ  byte i at [8*i+7:8*i]
//  ack        out  NUM_REQ    1-clk pulse: byte of requester i captured
//  done       out  NUM_REQ    1-clk pulse: byte of requester i fully transmitted
//  trmt       out  1          to UART_wrapper.trmt, 1-clk pulse
//  resp       out  8          to UART_wrapper.resp, held stable from trmt to done
//  tx_done    in   1          from UART_wrapper.tx_done (level, low while sending)
//  busy       out  1          high from grant until return to IDLE
//  to_err     out  1          1-clk pulse on transmit timeout (0 if macro absent)
// BEHAVIOUR
//  - All outputs registered. Reset: state=IDLE, ack=0, done=0, trmt=0,
//    resp=8'h00, busy=0, to_err=0, rr_ptr=NUM_REQ-1, so requester 0 wins first.
//  - States: IDLE -> LAUNCH -> WAIT_LOW -> WAIT_HIGH -> IDLE.
//  - IDLE: if |req, pick first set bit searching rr_ptr+1, rr_ptr+2, ... mod NUM_REQ.
//    At the next edge: resp<=req_data[g], owner<=g, rr_ptr<=g, ack[g]=1, trmt=1,
//    busy=1, state=LAUNCH. Latency: req sampled high -> ack/trmt 1 clk later.
//  - LAUNCH lasts exactly 1 clk (trmt high only here) -> WAIT_LOW.
//  - WAIT_LOW: stay until tx_done==0 -> WAIT_HIGH. This ignores the stale
//    tx_done level left high by the previous byte.
//  - WAIT_HIGH: on tx_done==1, pulse done[owner] for the next clk, busy=0,
//    state=IDLE. A new grant may be made on the clk after that (>=1 idle clk).
//  - Only one ack bit and one done bit are ever high. ack and done never coincide.
//  - Requests that arrive while busy are held by the requester. They are not queued here.
//  - Requester dropping req before ack: request withdrawn, no ack, no error.
//  - The owner's req/req_data changing after ack has no effect on resp.
//  - Only one requester: it may win back-to-back. Round robin guarantees each
//    of N active requesters is served within N grants.
//  - Reset mid-byte: returns to reset values next edge. No done is pulsed for
//    the aborted byte. The UART shares rst_n and restarts too.
//  - rr_ptr wraps NUM_REQ-1 -> 0. Out-of-range indices are never produced.
// CONFIGURATION
//  UART_ARB_TIMEOUT_EN defined: a counter (width $clog2(TO_CYCLES)) clears on
//    LAUNCH and counts in WAIT_LOW/WAIT_HIGH. On reaching TO_CYCLES-1: to_err
//    pulses 1 clk, no done pulse, busy=0, state=IDLE, rr_ptr is still advanced.
//  Undefined: no counter. WAIT_* wait indefinitely and to_err is tied 1'b0.
//    The port list is identical in both builds.
// TESTING
//  1 reset, req=3'b000 for 10 clks -> trmt, ack, done, busy all 0, resp=8'h00.
//  2 req[1]=1, data1=8'hA5; UART model drops tx_done 2 clks after trmt and raises
//    it 100 clks later -> ack=3'b010 and trmt 1 clk after req; resp=8'hA5 until
//    done=3'b010 1 clk after tx_done rises; exactly one trmt.
//  3 req=3'b111 held, data 8'h10/8'h20/8'h30 -> transmit order 10,20,30,10.
//    One ack per byte; rr_ptr wraps.
//  4 req[2] rises while byte of req[0] is in WAIT_HIGH -> no ack[2] until
//    done[0]; then ack[2] after >=1 idle clk.
//  5 rst_n=0 for 1 clk during WAIT_HIGH -> next clk all outputs at reset
//    values, no done pulse; req[0] next -> granted first.
//  6 UART_ARB_TIMEOUT_EN, TO_CYCLES=64, tx_done stuck 0 -> to_err pulses 64 clks
//    after trmt, no done, busy=0. Without the macro: busy stays 1 and to_err stays 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit path (trmt/resp/tx_done) among
// NUM_REQ byte sources with round-robin arbitration.
// Optional per-byte transmit timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned TO_CYCLES = 65536
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [8*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]     ack,
  output logic [NUM_REQ-1:0]     done,
  output logic                   trmt,
  output logic [7:0]             resp,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   to_err
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]           resp_q, resp_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 trmt_q, trmt_d;
  logic                 busy_q, busy_d;
  logic                 to_err_q, to_err_d;

  logic                 grant_vld;
  logic [IDX_W-1:0]     grant_idx;
  logic [7:0]           grant_byte;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = (TO_CYCLES > 2) ? $clog2(TO_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYCLES - 1);
  logic [CNT_W-1:0]     cnt_q, cnt_d;
`endif

  // Round-robin pick: first request above rr_ptr, else first from index 0
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_byte = 8'h00;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && req[i] && (IDX_W'(i) > rr_ptr_q)) begin
        grant_vld  = 1'b1;
        grant_idx  = IDX_W'(i);
        grant_byte = req_data[8*i +: 8];
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_vld && req[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = IDX_W'(i);
        grant_byte = req_data[8*i +: 8];
      end
    end
  end

  // Next-state and registered-output computation for the transmit sequence
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    resp_d   = resp_q;
    busy_d   = busy_q;
    ack_d    = '0;
    done_d   = '0;
    trmt_d   = 1'b0;
    to_err_d = 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif

    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          resp_d   = grant_byte;
          owner_d  = grant_idx;
          rr_ptr_d = grant_idx;
          ack_d    = NUM_REQ'(1) << grant_idx;
          trmt_d   = 1'b1;
          busy_d   = 1'b1;
          state_d  = LAUNCH;
        end
      end
      LAUNCH: begin
        state_d = WAIT_LOW;
      end
      // A stale high tx_done from the previous byte is skipped here
      WAIT_LOW: begin
        if (!tx_done) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (tx_done) begin
          done_d  = NUM_REQ'(1) << owner_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

`ifdef UART_ARB_TIMEOUT_EN
    // Byte watchdog: cleared at launch, aborts the byte when it expires
    if (state_q == LAUNCH) begin
      cnt_d = '0;
    end else if (state_q == WAIT_LOW || state_q == WAIT_HIGH) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_d == CNT_LAST && !(state_q == WAIT_HIGH && tx_done)) begin
        to_err_d = 1'b1;
        done_d   = '0;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
    end
`endif
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= LAST_IDX;
      resp_q   <= 8'h00;
      ack_q    <= '0;
      done_q   <= '0;
      trmt_q   <= 1'b0;
      busy_q   <= 1'b0;
      to_err_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      resp_q   <= resp_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      trmt_q   <= trmt_d;
      busy_q   <= busy_d;
      to_err_q <= to_err_d;
`ifdef UART_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Configuration sanity check on supported parameter ranges
  always_ff @(posedge clk) begin
    assert (NUM_REQ >= 2 && NUM_REQ <= 8 && TO_CYCLES >= 2);
  end

  assign ack    = ack_q;
  assign done   = done_q;
  assign trmt   = trmt_q;
  assign resp   = resp_q;
  assign busy   = busy_q;
  assign to_err = to_err_q;

endmodule
